// File: rtl/chan_select_reg.sv
// Registered N-channel selector with valid/ready handshakes, direct or round-robin selection.
// Optional transfer counter enabled by defining CHAN_SELECT_REG_CNT_EN.
module chan_select_reg #(
  parameter int unsigned NCH   = 6,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SELW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef CHAN_SELECT_REG_CNT_EN
  output logic [15:0]          xfer_cnt,
`endif
  output logic                 sel_err
);

  logic [SELW-1:0]  rr_ptr_q;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic [SELW-1:0]  chan_idx;
  logic             load_en;
  logic             sel_ok;
  logic             xfer;
  logic [WIDTH-1:0] chan_data;

  assign load_en = !out_valid || out_ready;
  assign sel_ok  = 32'(sel) < NCH;

  // First valid channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    int unsigned      idx;
    logic [NCH-1:0]   vshift;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    vshift      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      vshift = in_valid >> idx;
      if (!grant_valid && vshift[0]) begin
        grant_valid = 1'b1;
        grant       = SELW'(idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    chan_idx = mode ? grant : sel;
    if (!mode) begin
      if (sel_ok) in_ready = NCH'(load_en) << sel;
    end else if (grant_valid) begin
      in_ready = NCH'(load_en) << grant;
    end
  end

  assign xfer      = |(in_valid & in_ready);
  assign chan_data = WIDTH'(in_data >> (32'(chan_idx) * WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      sel_err   <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      sel_err <= !mode && !sel_ok;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= chan_data;
        out_chan  <= chan_idx;
        if (mode) rr_ptr_q <= (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CHAN_SELECT_REG_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_chan_select_reg.sv
// Directed bench for chan_select_reg: reference model and scoreboard checked every cycle,
// plus explicit checks of the directed scenarios.
module tb_chan_select_reg;
  localparam int NCH  = 6;
  localparam int W    = 4;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]  in_valid;
  logic [NCH-1:0]  in_ready;
  logic [SELW-1:0] sel;
  logic            mode;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;
  logic            sel_err;
`ifdef CHAN_SELECT_REG_CNT_EN
  logic [15:0]     xfer_cnt;
`endif

  chan_select_reg #(.NCH(NCH), .WIDTH(W), .SELW(SELW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef CHAN_SELECT_REG_CNT_EN
    .xfer_cnt (xfer_cnt),
`endif
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0]    d;
    logic [SELW-1:0] c;
  } word_t;

  word_t           sb[$];
  logic            m_valid = 1'b0;
  logic            m_sel_err = 1'b0;
  logic [SELW-1:0] m_rr = '0;
  logic [15:0]     m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    in_data[k*W +: W] = v;
  endtask

  // Reference model, advanced just before each rising edge.
  always @(negedge clk) begin : monitor
    logic [NCH-1:0]  exp_rdy;
    logic [SELW-1:0] g;
    logic            gv;
    logic            load;
    int              idx;
    word_t           w;
    if (reset) begin
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_data", 32'(out_data), 32'(0));
      chk("rst_chan", 32'(out_chan), 32'(0));
      chk("rst_sel_err", 32'(sel_err), 32'(0));
      sb.delete();
      m_valid   = 1'b0;
      m_sel_err = 1'b0;
      m_rr      = '0;
      m_cnt     = '0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid && sb.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(sb[0].d));
        chk("out_chan", 32'(out_chan), 32'(sb[0].c));
      end
      chk("sel_err", 32'(sel_err), 32'(m_sel_err));
`ifdef CHAN_SELECT_REG_CNT_EN
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
      load = !m_valid || out_ready;
      gv   = 1'b0;
      g    = '0;
      for (int i = 0; i < NCH; i++) begin
        idx = (int'(m_rr) + i) % NCH;
        if (!gv && in_valid[idx]) begin
          gv = 1'b1;
          g  = SELW'(idx);
        end
      end
      exp_rdy = '0;
      if (!mode) begin
        if (int'(sel) < NCH) exp_rdy[sel] = load;
      end else if (gv) begin
        exp_rdy[g] = load;
      end
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (m_valid && out_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (|(exp_rdy & in_valid)) begin
        w.c = mode ? g : sel;
        w.d = in_data[int'(w.c)*W +: W];
        sb.push_back(w);
        m_valid = 1'b1;
        if (mode) m_rr = (int'(g) == NCH - 1) ? '0 : g + 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      m_sel_err = !mode && (int'(sel) >= NCH);
    end
  end

  initial begin
    logic [SELW-1:0] exp_seq [11];
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd2, 3'd5, 3'd2, 3'd5};
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    sel       = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    reset = 1'b0;

    // Direct select of channel 3.
    for (int k = 0; k < NCH; k++) set_ch(k, W'(k));
    set_ch(3, 4'hA);
    sel      = 3'd3;
    in_valid = 6'b001000;
    #1;
    chk("dir_ready", 32'(in_ready), 32'(6'b001000));
    cyc();
    chk("dir_valid", 32'(out_valid), 32'(1));
    chk("dir_data", 32'(out_data), 32'(4'hA));
    chk("dir_chan", 32'(out_chan), 32'(3));

    // Unused selects never pass data.
    sel      = 3'd6;
    in_valid = 6'b111111;
    #1;
    chk("sel6_ready", 32'(in_ready), 32'(0));
    cyc();
    chk("sel6_valid", 32'(out_valid), 32'(0));
    chk("sel6_err", 32'(sel_err), 32'(1));
    sel = 3'd7;
    cyc();
    chk("sel7_err", 32'(sel_err), 32'(1));
    chk("sel7_ready", 32'(in_ready), 32'(0));

    // Backpressure holds the word and stalls upstream.
    sel = 3'd5;
    set_ch(5, 4'h5);
    cyc();
    chk("bp_load", 32'(out_data), 32'(4'h5));
    chk("bp_err_clear", 32'(sel_err), 32'(0));
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(5, W'(6 + i));
      #1;
      chk("bp_ready", 32'(in_ready), 32'(0));
      cyc();
      chk("bp_hold", 32'(out_data), 32'(4'h5));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'(6'b100000));
    cyc();
    chk("bp_release_data", 32'(out_data), 32'(4'h8));

    // Round-robin scan.
    mode = 1'b1;
    for (int k = 0; k < NCH; k++) set_ch(k, W'(k));
    for (int i = 0; i < 11; i++) begin
      if (i == 7) in_valid = 6'b100100;
      cyc();
      chk("rr_chan", 32'(out_chan), 32'(exp_seq[i]));
      chk("rr_data", 32'(out_data), 32'(exp_seq[i]));
    end

    // Bring rr_ptr to 4, then reset while holding a word.
    in_valid = 6'b111111;
    for (int i = 0; i < 4; i++) cyc();
    chk("pre_rst_chan", 32'(out_chan), 32'(3));
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'(0));
    chk("async_data", 32'(out_data), 32'(0));
    chk("async_chan", 32'(out_chan), 32'(0));
    cyc();
    set_ch(0, 4'hC);
    in_valid = 6'b110001;
    reset    = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'(6'b000001));
    cyc();
    chk("post_rst_chan", 32'(out_chan), 32'(0));
    chk("post_rst_data", 32'(out_data), 32'(4'hC));

    // Continuous handshakes.
    in_valid = 6'b111111;
    for (int i = 0; i < 10; i++) cyc();
`ifdef CHAN_SELECT_REG_CNT_EN
    chk("cnt_10", 32'(xfer_cnt), 32'(10));
    force dut.cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.cnt_q;
    for (int i = 0; i < 3; i++) cyc();
    chk("cnt_sat", 32'(xfer_cnt), 32'(16'hFFFF));
`endif

    in_valid = '0;
    cyc();
    cyc();
    chk("drain_valid", 32'(out_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
